// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and constants for the PS-PL FIFO push arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT)
//   STAT_W      : width of each per-producer accepted-word counter
//   BURST_W     : width of the in-grant burst counter
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int STAT_W  = 16;
  localparam int BURST_W = 8;

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// fifo_push_arbiter_if: producer-side and FIFO-side bus of the push arbiter.
//   req[N_REQ]           producer requests (valid)
//   data_in[N_REQ*WIDTH] producer words, slice i = [i*WIDTH +: WIDTH]
//   ack[N_REQ]           one-hot acceptance strobe
//   fifo_full            FIFO full flag
//   fifo_datain[WIDTH]   word to the FIFO
//   fifo_enw             FIFO write enable
// Modports: master = arbiter, slave = producers + FIFO.
//
// Handshake: req[i] acts as valid and must stay high with data_in slice i
// stable until ack[i]. A word transfers exactly at a rising edge where
// ack[i]=1; at that same edge the FIFO sees fifo_enw=1 and samples
// fifo_datain. ack is combinational, so "ready" is granted-and-not-full.
interface fifo_push_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] data_in;
  logic [N_REQ-1:0]       ack;
  logic                   fifo_full;
  logic [WIDTH-1:0]       fifo_datain;
  logic                   fifo_enw;

  modport master (
    input  req, data_in, fifo_full,
    output ack, fifo_datain, fifo_enw
  );

  modport slave (
    output req, data_in, fifo_full,
    input  ack, fifo_datain, fifo_enw
  );
endinterface

// File: rtl/fifo_push_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req[N_REQ]   request vector
//   last[IDX_W]  index granted most recently
//   winner       first set request at (last+1) mod N_REQ onwards, wrapping
//   any_req      high when any request is set (winner is 0 otherwise)
module rr_picker #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  // Scan starting just after last; last itself is visited last so a lone
  // requester that just finished can still win again.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!any_req && req[(int'(last) + k) % N_REQ]) begin
        any_req = 1'b1;
        winner  = IDX_W'((int'(last) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin sharing of the fifo_small write port among
// N_REQ producers, with a bounded burst per grant and fifo_full back-pressure.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         fifo_push_arbiter_if.master (req/data_in/ack, FIFO push side)
//   grant_id    current owner, meaningful only while busy=1
//   busy        high in GRANT
//   state_dbg   FSM state
//   word_count  per-producer saturating accepted-word counters
//               (only when ARB_STATS_EN is defined)
// Optional feature macro: ARB_STATS_EN.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int WIDTH     = 8,
  parameter  int MAX_BURST = 16,
  localparam int IDX_W     = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fifo_push_arbiter_if.master    bus,
  output logic [IDX_W-1:0]       grant_id,
  output logic                   busy,
  output arb_state_t             state_dbg
`ifdef ARB_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0] word_count
`endif
);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [BURST_W-1:0] burst_q, burst_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               enw;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req     (bus.req),
    .last    (last_q),
    .winner  (pick_idx),
    .any_req (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  // Outputs are combinational from registered state, so reset (which
  // forces IDLE asynchronously) blocks any write in the same cycle.
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_d          = last_q;
    burst_d         = burst_q;
    enw             = 1'b0;
    bus.fifo_enw    = 1'b0;
    bus.fifo_datain = '0;
    bus.ack         = '0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          burst_d = '0;
          state_d = GRANT;
        end
      end

      GRANT: begin
        enw             = bus.req[grant_q] & ~bus.fifo_full;
        bus.fifo_enw    = enw;
        bus.fifo_datain = bus.data_in[grant_q*WIDTH +: WIDTH];
        bus.ack         = N_REQ'(enw) << grant_q;

        if (!bus.req[grant_q]) begin
          // Producer drained: release without writing.
          state_d = IDLE;
          last_d  = grant_q;
        end else if (enw) begin
          burst_d = burst_q + BURST_W'(1);
          if (burst_q == BURST_W'(MAX_BURST - 1)) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign grant_id  = grant_q;
  assign busy      = (state_q == GRANT);
  assign state_dbg = state_q;

`ifdef ARB_STATS_EN
  for (genvar i = 0; i < N_REQ; i++) begin : g_stat
    logic [STAT_W-1:0] cnt_q;

    // Saturating: holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (bus.ack[i] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + STAT_W'(1);
      end
    end

    assign word_count[i*STAT_W +: STAT_W] = cnt_q;
  end
`endif

endmodule
